// File: rtl/fetch_unit.sv
// Instruction-fetch controller: issues req/ack fetches at the current PC, computes the
// next PC and its freeze, and owns the IF/ID slot (stall hold, branch flush, stale-fetch kill).
module fetch_unit #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Freeze,
  input  logic                  Branch_taken,
  input  logic [WORD_WIDTH-1:0] Branch_addr,
  input  logic [WORD_WIDTH-1:0] PC_cur,
  output logic [WORD_WIDTH-1:0] PC_next,
  output logic                  PC_freeze,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic                  IF_valid,
  output logic [WORD_WIDTH-1:0] IF_instr,
  output logic [WORD_WIDTH-1:0] IF_pc
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;

  state_t                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic [WORD_WIDTH-1:0]   instr_q, instr_d;
  logic [WORD_WIDTH-1:0]   ifpc_q, ifpc_d;
  logic [WORD_WIDTH-1:0]   buf_q, buf_d;
  logic [WORD_WIDTH-1:0]   bufpc_q, bufpc_d;
  logic [WORD_WIDTH-1:0]   kill_q, kill_d;
  logic [WORD_WIDTH-1:0]   pc_inc;

  // Sequential increment wraps modulo 2^WORD_WIDTH.
  function automatic logic [WORD_WIDTH-1:0] step_pc(input logic [WORD_WIDTH-1:0] pc);
    return pc + WORD_WIDTH'(PC_STEP);
  endfunction

  assign pc_inc = step_pc(PC_cur);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= RESET_PC;
      buf_q   <= '0;
      bufpc_q <= RESET_PC;
      kill_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    ifpc_d    = ifpc_q;
    buf_d     = buf_q;
    bufpc_d   = bufpc_q;
    kill_d    = kill_q;
    imem_req  = 1'b0;
    imem_addr = PC_cur;
    PC_freeze = 1'b1;
    PC_next   = PC_cur;

    case (state_q)
      IDLE: begin
        // One-cycle gap after reset; a branch arriving here is ignored.
        state_d = REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        if (Branch_taken) begin
          PC_freeze = 1'b0;
          PC_next   = Branch_addr;
          valid_d   = 1'b0;
          if (!imem_ack) begin
            // The in-flight request must still complete before a new one can issue.
            kill_d  = PC_cur;
            state_d = KILL;
          end
        end else if (imem_ack) begin
          if (!Freeze) begin
            instr_d   = imem_rdata;
            ifpc_d    = pc_inc;
            valid_d   = 1'b1;
            PC_freeze = 1'b0;
            PC_next   = pc_inc;
          end else begin
            buf_d   = imem_rdata;
            bufpc_d = pc_inc;
            state_d = HOLD;
          end
        end else if (!Freeze) begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (Branch_taken) begin
          PC_freeze = 1'b0;
          PC_next   = Branch_addr;
          valid_d   = 1'b0;
          state_d   = REQ;
        end else if (!Freeze) begin
          instr_d   = buf_q;
          ifpc_d    = bufpc_q;
          valid_d   = 1'b1;
          PC_freeze = 1'b0;
          PC_next   = pc_inc;
          state_d   = REQ;
        end
      end

      KILL: begin
        imem_req  = 1'b1;
        imem_addr = kill_q;
        if (Branch_taken) begin
          PC_freeze = 1'b0;
          PC_next   = Branch_addr;
          valid_d   = 1'b0;
        end
        if (imem_ack) begin
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign IF_valid = valid_q;
  assign IF_instr = instr_q;
  assign IF_pc    = ifpc_q;

endmodule
